// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I pipeline front end.
// Holds the data-path widths, the reset fetch address default, the canonical
// NOP encoding and the fetch slot record used by the instruction fetch stage.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One entry of the fetch slot queue: the PC it was fetched from, the
  // returned instruction word, and whether that word has arrived yet.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_queue.sv
// In-order fetch slot queue.
// A slot is allocated (with its PC) when a fetch request is accepted, filled
// when the matching response returns, and freed when decode takes it.
// Three circular pointers track the next slot to allocate, the oldest
// unfilled slot and the head slot presented to decode.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   clear_i            drop every slot and rewind all pointers
//   alloc_i/alloc_pc_i allocate a slot at the alloc pointer with this PC
//   fill_i/fill_data_i write the oldest unfilled slot and mark it filled
//   pop_i              free the head slot
//   head_o             current head slot
//   alloc_count_o      number of allocated slots (0..DEPTH)
//   unfilled_count_o   number of allocated slots still awaiting data
module fetch_slot_queue
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [ILEN-1:0] fill_data_i,
  input  logic            pop_i,
  output fetch_slot_t     head_o,
  output logic [CW-1:0]   alloc_count_o,
  output logic [CW-1:0]   unfilled_count_o
);

  fetch_slot_t slots_q [DEPTH];
  fetch_slot_t slots_d [DEPTH];

  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q,  fill_ptr_d;
  logic [PW-1:0] head_ptr_q,  head_ptr_d;
  logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0] unfill_cnt_q, unfill_cnt_d;

  // The alloc, fill and head slots are always distinct when their enables
  // are legal (alloc only when not full, fill only when something is
  // unfilled, pop only when the head is filled), so the writes below never
  // collide on one slot.
  always_comb begin
    slots_d      = slots_q;
    alloc_ptr_d  = alloc_ptr_q;
    fill_ptr_d   = fill_ptr_q;
    head_ptr_d   = head_ptr_q;
    alloc_cnt_d  = alloc_cnt_q;
    unfill_cnt_d = unfill_cnt_q;

    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_d[i].filled = 1'b0;
      end
      alloc_ptr_d  = '0;
      fill_ptr_d   = '0;
      head_ptr_d   = '0;
      alloc_cnt_d  = '0;
      unfill_cnt_d = '0;
    end else begin
      if (pop_i) begin
        slots_d[head_ptr_q].filled = 1'b0;
        head_ptr_d = head_ptr_q + PW'(1);
      end
      if (fill_i) begin
        slots_d[fill_ptr_q].instr  = fill_data_i;
        slots_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d = fill_ptr_q + PW'(1);
      end
      if (alloc_i) begin
        slots_d[alloc_ptr_q].pc     = alloc_pc_i;
        slots_d[alloc_ptr_q].filled = 1'b0;
        alloc_ptr_d = alloc_ptr_q + PW'(1);
      end
      alloc_cnt_d  = alloc_cnt_q + CW'(alloc_i) - CW'(pop_i);
      unfill_cnt_d = unfill_cnt_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_q[i] <= '0;
      end
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      head_ptr_q   <= '0;
      alloc_cnt_q  <= '0;
      unfill_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_q[i] <= slots_d[i];
      end
      alloc_ptr_q  <= alloc_ptr_d;
      fill_ptr_q   <= fill_ptr_d;
      head_ptr_q   <= head_ptr_d;
      alloc_cnt_q  <= alloc_cnt_d;
      unfill_cnt_q <= unfill_cnt_d;
    end
  end

  assign head_o           = slots_q[head_ptr_q];
  assign alloc_count_o    = alloc_cnt_q;
  assign unfilled_count_o = unfill_cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage of the 5-stage RV32I pipeline.
// Owns the fetch PC, issues word fetches to instruction memory, buffers the
// returned words in an in-order slot queue and hands {pc, instr, pc+4} to
// decode. A redirect from EX restarts fetch at a new PC; responses that were
// already in flight are counted in drop_cnt and discarded when they return.
//
// Handshakes: every valid/ready pair transfers exactly in a cycle where both
// are high at the rising clock edge. A valid, once raised, only depends on
// registered state (request port) or on registered state and redirect_i
// (decode port); no valid ever depends on its own ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_valid_o/ready_i fetch request handshake
//   imem_req_addr_o          word-aligned fetch address
//   imem_rsp_valid_i/data_i  in-order responses, no backpressure
//   redirect_i/redirect_pc_i EX redirect and its target
//   id_valid_o/id_ready_i    decode handshake
//   pc_o, instr_o, pc_plus4_o head instruction and its sequential successor
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            id_ready_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   alloc_count;
  logic [CW-1:0]   unfilled_count;
  fetch_slot_t     head;

  logic            req_hs;
  logic            fill_en;
  logic            pop_en;
  logic            head_show;
  logic [CW:0]     outstanding;
  logic [CW-1:0]   redirect_drop;

  // Every accepted request owns either an unfilled slot or a drop credit, so
  // this sum is the number of responses still owed by memory. Capping it at
  // FIFO_DEPTH keeps drop_cnt and the slot counters inside CW bits.
  assign outstanding = {1'b0, unfilled_count} + {1'b0, drop_cnt_q};

  assign imem_req_valid_o = ~rst
                          & (alloc_count < CW'(FIFO_DEPTH))
                          & (outstanding < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_hs           = imem_req_valid_o & imem_req_ready_i;

  // Responses go to a slot only once all stale responses have been skipped.
  assign fill_en = imem_rsp_valid_i & ~redirect_i
                 & (drop_cnt_q == '0) & (unfilled_count != '0);

  assign head_show  = head.filled & ~rst;
  assign id_valid_o = head_show & ~redirect_i;
  assign pop_en     = id_valid_o & id_ready_i;

  assign pc_o       = head_show ? head.pc : '0;
  assign instr_o    = head_show ? head.instr : '0;
  assign pc_plus4_o = head_show ? head.pc + XLEN'(4) : '0;

  fetch_slot_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_slots (
    .clk              (clk),
    .rst              (rst),
    .clear_i          (redirect_i),
    .alloc_i          (req_hs),
    .alloc_pc_i       (fetch_pc_q),
    .fill_i           (fill_en),
    .fill_data_i      (imem_rsp_data_i),
    .pop_i            (pop_en),
    .head_o           (head),
    .alloc_count_o    (alloc_count),
    .unfilled_count_o (unfilled_count)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;

    // On redirect every owed response becomes stale, including one accepted
    // this very cycle (it used the old PC); a response arriving now settles
    // one of them. The request cap guarantees this fits in CW bits.
    redirect_drop = outstanding[CW-1:0] + CW'(req_hs);
    if (imem_rsp_valid_i && (redirect_drop != '0)) begin
      redirect_drop = redirect_drop - CW'(1);
    end

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~XLEN'(3);
      drop_cnt_d = redirect_drop;
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (imem_rsp_valid_i && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // A response with nothing owed is a memory protocol violation; it is
  // ignored by the datapath above.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid_i && (drop_cnt_q == '0) && (unfilled_count == '0)))
        else $error("if_stage: imem response with no request outstanding");
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a latency-programmable in-order memory
// model and an expected-PC scoreboard for everything that reaches decode.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i  = 32'h0;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;

  if_stage #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_ready_i       (id_ready_i),
    .id_valid_o       (id_valid_o),
    .pc_o             (pc_o),
    .instr_o          (instr_o),
    .pc_plus4_o       (pc_plus4_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int checks  = 0;
  int errors  = 0;
  int req_cnt = 0;
  int dec_cnt = 0;
  int lat     = 1;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = RST_PC;
  int          due_q[$];
  logic [31:0] addr_q[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (id_valid_o !== 1'b1 && n < max_cyc) begin
      step(1);
      n++;
    end
    chk(tag, {31'b0, id_valid_o}, 32'd1);
  endtask

  // ---------------- memory model + scoreboard ----------------
  // Evaluated mid-cycle: inputs were driven just after the rising edge, so
  // everything seen here is what the next rising edge will act on.
  always @(negedge clk) begin
    logic [31:0] e;
    logic        hs;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
    if (rst) begin
      due_q.delete();
      addr_q.delete();
      exp_q.delete();
      exp_addr = RST_PC;
    end else begin
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = instr_of(addr_q[0]);
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end

      if (id_valid_o && id_ready_i) begin
        dec_cnt++;
        if (exp_q.size() == 0) begin
          chk("dec_unexpected", {31'b0, id_valid_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dec_pc", pc_o, e);
          chk("dec_instr", instr_o, instr_of(e));
          chk("dec_pc4", pc_plus4_o, e + 32'd4);
        end
      end

      if (redirect_i) chk("id_valid_masked", {31'b0, id_valid_o}, 32'd0);
      if (imem_req_valid_o) chk("req_addr", imem_req_addr_o, exp_addr);

      hs = imem_req_valid_o && imem_req_ready_i;
      if (hs) begin
        req_cnt++;
        due_q.push_back(cyc + lat);
        addr_q.push_back(imem_req_addr_o);
      end

      if (redirect_i) begin
        exp_q.delete();
        exp_addr = redirect_pc_i & ~32'h3;
      end else if (hs) begin
        exp_q.push_back(exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n0;
    int r0;
    rst = 1'b1; imem_req_ready_i = 1'b1; id_ready_i = 1'b1;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; lat = 1;

    // Reset state
    step(3);
    chk("rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    chk("rst_id_valid", {31'b0, id_valid_o}, 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc4", pc_plus4_o, 32'h0);

    // First request, 2-cycle latency, streaming throughput
    rst = 1'b0; #1;
    chk("first_req_valid", {31'b0, imem_req_valid_o}, 32'd1);
    chk("first_req_addr", imem_req_addr_o, RST_PC);
    step(1);
    chk("lat_not_early", {31'b0, id_valid_o}, 32'd0);
    step(1);
    chk("lat_valid", {31'b0, id_valid_o}, 32'd1);
    chk("lat_pc", pc_o, RST_PC);
    chk("lat_pc4", pc_plus4_o, RST_PC + 32'd4);
    n0 = dec_cnt; r0 = req_cnt;
    step(10);
    chk("stream_dec", n0 + 10, dec_cnt);
    chk("stream_req", r0 + 10, req_cnt);

    // Decode stall: only FIFO_DEPTH requests issue, head held stable
    rst = 1'b1; id_ready_i = 1'b0;
    step(2);
    rst = 1'b0; r0 = req_cnt;
    step(5);
    chk("stall_pc_mid", pc_o, RST_PC);
    step(5);
    chk("stall_req_cnt", r0 + 4, req_cnt);
    chk("stall_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    chk("stall_id_valid", {31'b0, id_valid_o}, 32'd1);
    chk("stall_pc", pc_o, RST_PC);
    chk("stall_instr", instr_o, instr_of(RST_PC));
    id_ready_i = 1'b1; n0 = dec_cnt;
    step(8);
    chk("drain_dec", n0 + 8, dec_cnt);

    // Reset with the queue full
    id_ready_i = 1'b0;
    step(8);
    chk("full_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    chk("full_id_valid", {31'b0, id_valid_o}, 32'd1);
    rst = 1'b1;
    step(1);
    chk("midrst_id_valid", {31'b0, id_valid_o}, 32'd0);
    chk("midrst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    rst = 1'b0; id_ready_i = 1'b1; #1;
    chk("midrst_req_addr", imem_req_addr_o, RST_PC);
    chk("midrst_req_valid2", {31'b0, imem_req_valid_o}, 32'd1);
    step(6);

    // 3-cycle memory, redirect with two requests in flight
    rst = 1'b1; lat = 3; imem_req_ready_i = 1'b0;
    step(1);
    rst = 1'b0; imem_req_ready_i = 1'b1;
    step(2);
    imem_req_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    step(1);
    redirect_i = 1'b0; imem_req_ready_i = 1'b1; #1;
    chk("redir_req_valid", {31'b0, imem_req_valid_o}, 32'd1);
    chk("redir_req_addr", imem_req_addr_o, 32'h0000_0100);
    wait_valid("redir_wait", 20);
    chk("redir_pc", pc_o, 32'h0000_0100);
    chk("redir_instr", instr_o, instr_of(32'h0000_0100));

    // Redirect coinciding with a request handshake and a response
    rst = 1'b1; lat = 1; imem_req_ready_i = 1'b1; id_ready_i = 1'b1;
    step(1);
    rst = 1'b0;
    step(8);
    chk("coll_req_addr", imem_req_addr_o, 32'h0000_0020);
    chk("coll_rsp_valid", {31'b0, imem_rsp_valid_i}, 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    step(1);
    redirect_i = 1'b0;
    wait_valid("coll_wait", 20);
    chk("coll_pc", pc_o, 32'h0000_0200);
    chk("coll_instr", instr_o, instr_of(32'h0000_0200));

    // PC wrap at 2^32
    id_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    step(1);
    redirect_i = 1'b0;
    chk("wrap_req_addr0", imem_req_addr_o, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_req_addr1", imem_req_addr_o, 32'h0000_0000);
    wait_valid("wrap_wait", 20);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_o, 32'h0000_0000);
    id_ready_i = 1'b1;
    step(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
